// File: rtl/vp_gfx_packer_pkg.sv
// vp_gfx_packer_pkg: shared constants, FSM state type and cell-placement
// helper for the graphics character packer.
// Optional feature macro: GFX_PACKER_MOSAIC_EN (separated-mosaic sampling).
package vp_gfx_packer_pkg;

  // Character geometry: 20 pixel rows grouped into 5 bands of 4 rows.
  localparam logic [4:0] GFX_CHAR_ROWS        = 5'd20;
  localparam logic [4:0] GFX_BAND_ROWS        = 5'd4;

  // A cell lights when its counted pixels reach these values.
  localparam logic [4:0] GFX_NORMAL_THRESHOLD = 5'd8;
  localparam logic [4:0] GFX_MOSAIC_THRESHOLD = 5'd2;

  // Derived constants.
  localparam int         GFX_CELL_BITS        = 20;
  localparam int         GFX_NIBBLES          = 4;
  localparam logic [4:0] GFX_LAST_ROW         = GFX_CHAR_ROWS - 5'd1;
  localparam logic [1:0] GFX_BAND_LAST        = 2'(GFX_BAND_ROWS - 5'd1);

  typedef logic [4:0] gfx_row_idx_t;   // 0..19
  typedef logic [4:0] gfx_pix_cnt_t;   // 0..16 pixels per cell
  typedef logic [2:0] gfx_nib_cnt_t;   // 0..4 pixels per nibble

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } gfx_state_e;

  // Place a 4-bit band code (bit 3 = leftmost cell) into its slot of the
  // 20-bit cell code; band 0 occupies bits 19:16.
  function automatic logic [GFX_CELL_BITS-1:0] gfx_band_place(
    input logic [3:0] band_bits,
    input logic [2:0] band
  );
    return {band_bits, 16'h0000} >> {band, 2'b00};
  endfunction

endpackage

// File: rtl/vp_gfx_packer_if.sv
// vp_gfx_packer_if: row input handshake and packed-cell output handshake.
// The mosaic signal exists only when GFX_PACKER_MOSAIC_EN is defined.
interface vp_gfx_packer_if;

  // Row side
  logic [3:0]  foreground;
  logic [3:0]  background;
  logic [15:0] row_bitmap;
  logic        row_first;
`ifdef GFX_PACKER_MOSAIC_EN
  logic        mosaic;
`endif
  logic        row_valid;
  logic        row_ready;

  // Result side
  logic [19:0] gfx_bits;
  logic [3:0]  gfx_foreground;
  logic [3:0]  gfx_background;
  logic        gfx_valid;
  logic        gfx_ready;

  // Row producer and result consumer.
  modport master (
    output foreground, background, row_bitmap, row_first,
`ifdef GFX_PACKER_MOSAIC_EN
    output mosaic,
`endif
    output row_valid, gfx_ready,
    input  row_ready, gfx_bits, gfx_foreground, gfx_background, gfx_valid
  );

  // The packer itself.
  modport slave (
    input  foreground, background, row_bitmap, row_first,
`ifdef GFX_PACKER_MOSAIC_EN
    input  mosaic,
`endif
    input  row_valid, gfx_ready,
    output row_ready, gfx_bits, gfx_foreground, gfx_background, gfx_valid
  );

endinterface

// File: rtl/vp_gfx_nibble_count.sv
// vp_gfx_nibble_count: counts set pixels in one 4-pixel nibble of a row.
// In mosaic mode only the two inner pixels (bits 2 and 1) are counted.
module vp_gfx_nibble_count
  import vp_gfx_packer_pkg::*;
(
  input  logic         [3:0] nibble_i,
  input  logic               mosaic_i,
  output gfx_nib_cnt_t       count_o
);

  // Population count of the selected pixel columns.
  always_comb begin
    if (mosaic_i) begin
      count_o = {2'b00, nibble_i[2]} + {2'b00, nibble_i[1]};
    end else begin
      count_o = {2'b00, nibble_i[3]} + {2'b00, nibble_i[2]}
              + {2'b00, nibble_i[1]} + {2'b00, nibble_i[0]};
    end
  end

endmodule

// File: rtl/vp_gfx_packer.sv
// vp_gfx_packer: accumulates 20 rows of a 16-pixel-wide character and
// reduces them to a 4x5 block-graphics cell code plus captured colours.
// Each band of 4 rows feeds four pixel counters (one per nibble column);
// at the last row of a band the counters are thresholded into 4 cell bits.
// Optional feature macro: GFX_PACKER_MOSAIC_EN adds the mosaic input and
// separated-mosaic sampling; without it every character uses normal mode.
module vp_gfx_packer
  import vp_gfx_packer_pkg::*;
(
  input logic            clk,
  input logic            reset,
  vp_gfx_packer_if.slave bus
);

  gfx_state_e                            state_q, state_d;
  logic                                  xfer;
  logic                                  row_start;   // row 0 accepted
  logic                                  row_take;    // row 1..19 accepted

  gfx_row_idx_t                          row_cnt_q, row_cnt_d;
  gfx_row_idx_t                          row_idx;
  logic [1:0]                            band_phase;
  logic [2:0]                            band_idx;

  logic [GFX_NIBBLES-1:0][4:0]           cnt_q, cnt_d;
  logic [GFX_NIBBLES-1:0][4:0]           band_sum;
  logic [GFX_NIBBLES-1:0][2:0]           nib_cnt;
  logic [GFX_NIBBLES-1:0]                cell_hit;
  logic [3:0]                            band_code;
  logic [GFX_CELL_BITS-1:0]              part_base;
  logic [GFX_CELL_BITS-1:0]              part_merged;
  logic [GFX_CELL_BITS-1:0]              part_q, part_d;

  logic [3:0]                            cap_fg_q, cap_fg_d;
  logic [3:0]                            cap_bg_q, cap_bg_d;
  logic [GFX_CELL_BITS-1:0]              gfx_bits_q, gfx_bits_d;
  logic [3:0]                            gfx_fg_q, gfx_fg_d;
  logic [3:0]                            gfx_bg_q, gfx_bg_d;

  logic                                  mos_now;
  logic                                  count_row;
  gfx_pix_cnt_t                          threshold;

  // NOTE: row_ready is gated combinationally by reset so no row can slip in
  // during the reset cycle; the state register alone would still read DONE.
  assign bus.row_ready      = ~reset & (state_q != DONE);
  assign xfer               = bus.row_valid & bus.row_ready;

  assign bus.gfx_valid      = (state_q == DONE);
  assign bus.gfx_bits       = gfx_bits_q;
  assign bus.gfx_foreground = gfx_fg_q;
  assign bus.gfx_background = gfx_bg_q;

`ifdef GFX_PACKER_MOSAIC_EN
  logic cap_mos_q;

  // Row 0 uses the live mosaic input; later rows use the captured value.
  assign mos_now = row_start ? bus.mosaic : cap_mos_q;

  // Capture the mosaic mode with row 0 and hold it for the character.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_mos_q <= 1'b0;
    end else begin
      cap_mos_q <= mos_now;
    end
  end
`else
  assign mos_now = 1'b0;
`endif

  // Per-nibble pixel counters for the row being accepted.
  for (genvar g = 0; g < GFX_NIBBLES; g++) begin : g_nib
    vp_gfx_nibble_count u_nib_count (
      .nibble_i (bus.row_bitmap[15-4*g -: 4]),
      .mosaic_i (mos_now),
      .count_o  (nib_cnt[g])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and row acceptance classification.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    row_start = 1'b0;
    row_take  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Rows without row_first are dropped while idle.
        if (xfer && bus.row_first) begin
          row_start = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (bus.row_first) begin
            row_start = 1'b1;
          end else begin
            row_take = 1'b1;
            if (row_cnt_q == GFX_LAST_ROW) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (bus.gfx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row position, counting mode and band thresholding for the accepted row.
  always_comb begin
    row_idx    = row_start ? '0 : row_cnt_q;
    band_phase = row_idx[1:0];
    band_idx   = row_idx[4:2];
    // Mosaic mode counts only band-relative rows 1 and 2.
    count_row  = ~mos_now | (band_phase == 2'd1) | (band_phase == 2'd2);
    threshold  = mos_now ? GFX_MOSAIC_THRESHOLD : GFX_NORMAL_THRESHOLD;
    band_sum   = '0;
    cell_hit   = '0;
    for (int g = 0; g < GFX_NIBBLES; g++) begin
      band_sum[g] = (row_start ? 5'd0 : cnt_q[g])
                  + (count_row ? {2'b00, nib_cnt[g]} : 5'd0);
      cell_hit[g] = (band_sum[g] >= threshold);
    end
    // Nibble 0 is the leftmost cell, i.e. the most significant band bit.
    band_code   = {cell_hit[0], cell_hit[1], cell_hit[2], cell_hit[3]};
    part_base   = row_start ? '0 : part_q;
    part_merged = (part_base & ~gfx_band_place(4'hF, band_idx))
                | gfx_band_place(band_code, band_idx);
  end

  // Datapath next-state: counters, partial cell code, colours and outputs.
  always_comb begin
    row_cnt_d  = row_cnt_q;
    cnt_d      = cnt_q;
    part_d     = part_q;
    cap_fg_d   = cap_fg_q;
    cap_bg_d   = cap_bg_q;
    gfx_bits_d = gfx_bits_q;
    gfx_fg_d   = gfx_fg_q;
    gfx_bg_d   = gfx_bg_q;
    if (row_start || row_take) begin
      row_cnt_d = row_idx + 5'd1;
      if (row_start) begin
        // A new row 0 discards any partial character and recaptures colours.
        cap_fg_d = bus.foreground;
        cap_bg_d = bus.background;
        part_d   = '0;
      end
      if (band_phase == GFX_BAND_LAST) begin
        cnt_d  = '0;
        part_d = part_merged;
      end else begin
        cnt_d  = band_sum;
      end
      // Outputs change only when the last row completes the character.
      if (row_take && (row_idx == GFX_LAST_ROW)) begin
        row_cnt_d  = '0;
        gfx_bits_d = part_merged;
        gfx_fg_d   = cap_fg_q;
        gfx_bg_d   = cap_bg_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset, counters included, so a reset in
    // the middle of a character leaves no stale partial state behind.
    if (reset) begin
      row_cnt_q  <= '0;
      cnt_q      <= '0;
      part_q     <= '0;
      cap_fg_q   <= '0;
      cap_bg_q   <= '0;
      gfx_bits_q <= '0;
      gfx_fg_q   <= '0;
      gfx_bg_q   <= '0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      cnt_q      <= cnt_d;
      part_q     <= part_d;
      cap_fg_q   <= cap_fg_d;
      cap_bg_q   <= cap_bg_d;
      gfx_bits_q <= gfx_bits_d;
      gfx_fg_q   <= gfx_fg_d;
      gfx_bg_q   <= gfx_bg_d;
    end
  end

endmodule

// File: tb/tb_vp_gfx_packer.sv
// tb_vp_gfx_packer: directed and randomized characters checked against a
// cell-level reference model that counts pixels per 4x4 (or mosaic 2x2)
// block straight from the row bitmaps.
module tb_vp_gfx_packer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vp_gfx_packer_if bus ();

  vp_gfx_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] cur_rows [20];
  logic [19:0] held_bits;
  logic [3:0]  held_fg;
  logic [3:0]  held_bg;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mosaic(input logic m);
`ifdef GFX_PACKER_MOSAIC_EN
    bus.mosaic = m;
`endif
  endtask

  // Reference: each cell counts the pixels of its 4x4 block (or the inner
  // 2x2 in mosaic mode) and lights when the count reaches the threshold.
  function automatic logic [19:0] model_char(input logic mos);
    logic [19:0] res;
    int          cnt;
    int          sh;
    res = '0;
    for (int b = 0; b < 5; b++) begin
      for (int g = 0; g < 4; g++) begin
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
          for (int c = 0; c < 4; c++) begin
            sh = 15 - 4*g - c;
            if (!mos || ((k == 1 || k == 2) && (c == 1 || c == 2)))
              cnt += int'((cur_rows[4*b+k] >> sh) & 16'h1);
          end
        end
        res = {res[18:0], (cnt >= (mos ? 2 : 8))};
      end
    end
    return res;
  endfunction

  task automatic fill_random(input int density);
    logic [15:0] row;
    for (int r = 0; r < 20; r++) begin
      row = '0;
      for (int i = 0; i < 16; i++)
        row = {row[14:0], ($urandom_range(0, 15) < density)};
      cur_rows[r] = row;
    end
  endtask

  // Non-transfer cycle with junk on every row input.
  task automatic idle_cycle();
    bus.row_valid  = 1'b0;
    bus.row_bitmap = 16'($urandom);
    bus.row_first  = 1'($urandom);
    bus.foreground = 4'($urandom);
    bus.background = 4'($urandom);
    set_mosaic(1'($urandom));
    tick();
    check("valid_idle_gap", bus.gfx_valid, 1'b0);
  endtask

  task automatic send_row(input logic [15:0] bm, input logic first,
                          input logic [3:0] fg, input logic [3:0] bg);
    bus.row_valid  = 1'b1;
    bus.row_bitmap = bm;
    bus.row_first  = first;
    bus.foreground = fg;
    bus.background = bg;
    tick();
    bus.row_valid  = 1'b0;
  endtask

  // Send cur_rows as one character and check the result and handshake.
  task automatic run_char(input logic [3:0] fg, input logic [3:0] bg, input logic mos,
                          input logic [19:0] exp_bits, input int hold, input bit gaps);
    for (int r = 0; r < 20; r++) begin
      if (gaps) begin
        for (int i = $urandom_range(0, 2); i > 0; i--) idle_cycle();
      end
      bus.row_valid  = 1'b1;
      bus.row_bitmap = cur_rows[r];
      bus.row_first  = (r == 0);
      bus.foreground = (r == 0) ? fg : 4'($urandom);
      bus.background = (r == 0) ? bg : 4'($urandom);
      set_mosaic((r == 0) ? mos : 1'($urandom));
      #1;
      check("ready_accum", bus.row_ready, 1'b1);
      check("valid_accum", bus.gfx_valid, 1'b0);
      check("bits_held", bus.gfx_bits, held_bits);
      check("fg_held", bus.gfx_foreground, held_fg);
      check("bg_held", bus.gfx_background, held_bg);
      tick();
    end
    bus.row_valid = 1'b0;
    check("valid_done", bus.gfx_valid, 1'b1);
    check("bits_done", bus.gfx_bits, exp_bits);
    check("fg_done", bus.gfx_foreground, fg);
    check("bg_done", bus.gfx_background, bg);
    check("ready_done", bus.row_ready, 1'b0);
    // Hold the consumer off while offering a row 0 that must not be taken.
    for (int h = 0; h < hold; h++) begin
      bus.row_valid  = 1'b1;
      bus.row_first  = 1'b1;
      bus.row_bitmap = 16'($urandom);
      bus.foreground = 4'($urandom);
      tick();
      check("valid_hold", bus.gfx_valid, 1'b1);
      check("bits_hold", bus.gfx_bits, exp_bits);
      check("fg_hold", bus.gfx_foreground, fg);
      check("ready_hold", bus.row_ready, 1'b0);
    end
    bus.row_valid = 1'b0;
    bus.gfx_ready = 1'b1;
    tick();
    bus.gfx_ready = 1'b0;
    check("valid_release", bus.gfx_valid, 1'b0);
    check("ready_release", bus.row_ready, 1'b1);
    check("bits_release", bus.gfx_bits, exp_bits);
    held_bits = exp_bits;
    held_fg   = fg;
    held_bg   = bg;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       mos;
    logic [3:0] fg;
    logic [3:0] bg;

    reset          = 1'b1;
    bus.row_valid  = 1'b0;
    bus.row_first  = 1'b0;
    bus.row_bitmap = '0;
    bus.foreground = '0;
    bus.background = '0;
    bus.gfx_ready  = 1'b0;
    set_mosaic(1'b0);
    held_bits = '0;
    held_fg   = '0;
    held_bg   = '0;

    // Reset state
    tick();
    tick();
    check("ready_in_reset", bus.row_ready, 1'b0);
    check("valid_in_reset", bus.gfx_valid, 1'b0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", bus.row_ready, 1'b1);
    check("bits_after_reset", bus.gfx_bits, 20'h0);
    check("fg_after_reset", bus.gfx_foreground, 4'h0);
    check("bg_after_reset", bus.gfx_background, 4'h0);

    // All pixels set
    for (int r = 0; r < 20; r++) cur_rows[r] = 16'hFFFF;
    run_char(4'hA, 4'h3, 1'b0, 20'hFFFFF, 0, 1'b0);

    // Single top-left cell, full and at-threshold; below threshold
    for (int r = 0; r < 20; r++) cur_rows[r] = (r < 4) ? 16'hF000 : 16'h0000;
    run_char(4'h1, 4'h2, 1'b0, 20'h80000, 1, 1'b1);
    for (int r = 0; r < 20; r++) cur_rows[r] = (r < 4) ? 16'hC000 : 16'h0000;
    run_char(4'h4, 4'h5, 1'b0, 20'h80000, 0, 1'b0);
    for (int r = 0; r < 20; r++) cur_rows[r] = (r < 2) ? 16'hE000 : 16'h0000;
    run_char(4'h7, 4'h8, 1'b0, 20'h00000, 0, 1'b1);

`ifdef GFX_PACKER_MOSAIC_EN
    // Mosaic: only inner rows/columns count
    for (int r = 0; r < 20; r++)
      cur_rows[r] = (r % 4 == 1 || r % 4 == 2) ? 16'h6666 : 16'hFFFF;
    run_char(4'hC, 4'hD, 1'b1, 20'hFFFFF, 0, 1'b0);
    for (int r = 0; r < 20; r++)
      cur_rows[r] = (r % 4 == 1 || r % 4 == 2) ? 16'h9999 : 16'h0000;
    run_char(4'hE, 4'hF, 1'b1, 20'h00000, 0, 1'b0);
`endif

    // Consumer stalls for 5 cycles in DONE
    fill_random(8);
    run_char(4'h9, 4'h6, 1'b0, model_char(1'b0), 5, 1'b0);

    // Restart with row_first at row 10
    fill_random(12);
    for (int r = 0; r < 10; r++) send_row(cur_rows[r], (r == 0), 4'h5, 4'hB);
    check("valid_before_restart", bus.gfx_valid, 1'b0);
    fill_random(6);
    run_char(4'h6, 4'h9, 1'b0, model_char(1'b0), 0, 1'b0);

    // Reset at row 12, then an orphan row, then a clean character
    fill_random(10);
    for (int r = 0; r < 12; r++) send_row(cur_rows[r], (r == 0), 4'h2, 4'h4);
    reset          = 1'b1;
    bus.row_valid  = 1'b1;
    bus.row_first  = 1'b1;
    #1;
    check("ready_mid_reset", bus.row_ready, 1'b0);
    tick();
    reset         = 1'b0;
    bus.row_valid = 1'b0;
    #1;
    check("valid_post_reset", bus.gfx_valid, 1'b0);
    check("bits_post_reset", bus.gfx_bits, 20'h0);
    check("fg_post_reset", bus.gfx_foreground, 4'h0);
    check("bg_post_reset", bus.gfx_background, 4'h0);
    check("ready_post_reset", bus.row_ready, 1'b1);
    held_bits = '0;
    held_fg   = '0;
    held_bg   = '0;
    send_row(16'hFFFF, 1'b0, 4'hF, 4'hF);
    check("valid_orphan_row", bus.gfx_valid, 1'b0);
    fill_random(9);
    run_char(4'h3, 4'hA, 1'b0, model_char(1'b0), 0, 1'b0);

    // Randomized characters
    for (int n = 0; n < 12; n++) begin
      fill_random(int'($urandom_range(0, 16)));
      fg  = 4'($urandom);
      bg  = 4'($urandom);
      mos = 1'b0;
`ifdef GFX_PACKER_MOSAIC_EN
      mos = 1'($urandom);
`endif
      run_char(fg, bg, mos, model_char(mos), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
